// File: rtl/ppm_detect_core.sv
// PPM capture core: times rise-to-rise intervals of the receiver input
// and publishes complete frames atomically to the register file.
module ppm_detect_core #(
  parameter int NUM_CH   = 6,
  parameter int CNT_W    = 32,
  parameter int SYNC_MIN = 250000,
  parameter int TIMEOUT  = 5000000
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    enable,
  input  logic                    ppm_in,
  output logic [NUM_CH*CNT_W-1:0] ch_width,
  output logic                    frame_valid,
  output logic [15:0]             frame_count,
  output logic [7:0]              err_count,
  output logic                    signal_lost,
  output logic [1:0]              state_dbg
);

  localparam int IW = $clog2(NUM_CH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SYNC = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;

  localparam logic [CNT_W-1:0] SYNC_V = CNT_W'(SYNC_MIN);
  localparam logic [CNT_W-1:0] TO_V   = CNT_W'(TIMEOUT);
  localparam logic [IW-1:0]    LAST   = IW'(NUM_CH);

  logic                    s1_q, s2_q, s3_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [1:0]              state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CNT_W-1:0]        shadow_q [NUM_CH];
  logic [CNT_W-1:0]        shadow_d [NUM_CH];
  logic [NUM_CH*CNT_W-1:0] width_q, width_d;
  logic                    fv_q, fv_d;
  logic [15:0]             fc_q, fc_d;
  logic [7:0]              ec_q, ec_d;
  logic                    lost_q, lost_d;

  logic             rise;
  logic             is_gap;
  logic             tmo;
  logic             full;
  logic [CNT_W-1:0] interval;
  logic [7:0]       ec_inc;

  assign rise     = s2_q & ~s3_q;
  assign interval = cnt_q + CNT_W'(1);
  assign is_gap   = interval >= SYNC_V;
  assign tmo      = cnt_q >= TO_V;
  assign full     = idx_q == LAST;
  assign ec_inc   = (ec_q == 8'hFF) ? ec_q : ec_q + 8'd1;

  always_comb begin
    cnt_d    = cnt_q;
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    width_d  = width_q;
    fv_d     = 1'b0;
    fc_d     = fc_q;
    ec_d     = ec_q;
    lost_d   = lost_q;
    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (rise) begin
      // a rise always wins over a coincident timeout
      cnt_d = '0;
      unique case (1'b1)
        state_q == S_IDLE: begin
          if (is_gap) state_d = S_SYNC;
        end
        state_q == S_SYNC: begin
          state_d = S_CAPT;
          idx_d   = '0;
        end
        state_q == S_CAPT: begin
          if (!is_gap) begin
            if (full) begin
              ec_d    = ec_inc;
              state_d = S_IDLE;
              idx_d   = '0;
            end else begin
              for (int k = 0; k < NUM_CH; k++)
                if (idx_q == IW'(k)) shadow_d[k] = interval;
              idx_d = idx_q + IW'(1);
            end
          end else begin
            if (full) begin
              for (int k = 0; k < NUM_CH; k++)
                width_d[k*CNT_W +: CNT_W] = shadow_q[k];
              fv_d   = 1'b1;
              fc_d   = fc_q + 16'd1;
              lost_d = 1'b0;
            end else begin
              ec_d = ec_inc;
            end
            state_d = S_SYNC;
            idx_d   = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
      endcase
    end else if (tmo) begin
      lost_d  = 1'b1;
      state_d = S_IDLE;
      idx_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      cnt_q   <= '0;
      state_q <= S_IDLE;
      idx_q   <= '0;
      for (int k = 0; k < NUM_CH; k++) shadow_q[k] <= '0;
      width_q <= '0;
      fv_q    <= 1'b0;
      fc_q    <= '0;
      ec_q    <= '0;
      lost_q  <= 1'b0;
    end else begin
      s1_q     <= ppm_in;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      width_q  <= width_d;
      fv_q     <= fv_d;
      fc_q     <= fc_d;
      ec_q     <= ec_d;
      lost_q   <= lost_d;
    end
  end

  assign ch_width    = width_q;
  assign frame_valid = fv_q;
  assign frame_count = fc_q;
  assign err_count   = ec_q;
  assign signal_lost = lost_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_ppm_detect_core.sv
// Scoreboard bench for ppm_detect_core: a frame-level model predicts
// every commit and a monitor checks each frame_valid against it.
module tb_ppm_detect_core;

  localparam int NUM_CH   = 6;
  localparam int CNT_W    = 32;
  localparam int SYNC_MIN = 1000;
  localparam int TIMEOUT  = 10000;
  localparam int PW       = 20;
  localparam int WW       = NUM_CH * CNT_W;

  logic          ACLK    = 1'b0;
  logic          ARESETN = 1'b0;
  logic          enable  = 1'b0;
  logic          ppm_in  = 1'b0;
  logic [WW-1:0] ch_width;
  logic          frame_valid;
  logic [15:0]   frame_count;
  logic [7:0]    err_count;
  logic          signal_lost;
  logic [1:0]    state_dbg;

  ppm_detect_core #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W),
    .SYNC_MIN(SYNC_MIN), .TIMEOUT(TIMEOUT)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .enable(enable), .ppm_in(ppm_in),
    .ch_width(ch_width), .frame_valid(frame_valid),
    .frame_count(frame_count), .err_count(err_count),
    .signal_lost(signal_lost), .state_dbg(state_dbg)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [WW-1:0] w;
    logic [15:0]   fc;
    logic [7:0]    ec;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [WW-1:0] exp_w = '0;
  int            n_chk = 0;
  int            n_fail = 0;

  // model: channels gathered since the lead rise, plus frame phase
  int cur[$];
  bit in_frame  = 0;
  bit wait_lead = 0;
  bit m_lost    = 0;
  int m_fc      = 0;
  int m_err     = 0;

  task automatic check(string nm, logic [WW-1:0] act,
                       logic [WW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model_idle();
    cur.delete();
    in_frame  = 0;
    wait_lead = 0;
  endfunction

  function automatic int exp_state();
    return wait_lead ? 1 : (in_frame ? 2 : 0);
  endfunction

  function automatic void bump_err();
    if (m_err < 255) m_err++;
  endfunction

  function automatic void model_rise(int p);
    exp_t e;
    bit   gap;
    if (p > TIMEOUT + 1) begin
      m_lost = 1;
      model_idle();
      p = TIMEOUT + 1;
    end
    gap = p >= SYNC_MIN;
    if (wait_lead) begin
      wait_lead = 0;
      in_frame  = 1;
      cur.delete();
    end else if (in_frame) begin
      if (!gap) begin
        if (cur.size() == NUM_CH) begin
          bump_err();
          model_idle();
        end else cur.push_back(p);
      end else begin
        if (cur.size() == NUM_CH) begin
          e.w = '0;
          for (int k = 0; k < NUM_CH; k++)
            e.w[k*CNT_W +: CNT_W] = CNT_W'(cur[k]);
          m_fc   = (m_fc + 1) & 'hFFFF;
          e.fc   = 16'(m_fc);
          e.ec   = 8'(m_err);
          m_lost = 0;
          sb.push_back(e);
        end else bump_err();
        model_idle();
        wait_lead = 1;
      end
    end else if (gap) begin
      wait_lead = 1;
    end
  endfunction

  always @(negedge ACLK) begin
    if (!ARESETN) begin
      exp_w = '0;
    end else if (frame_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_commit: got frame_valid expected none");
      end else begin
        mon_e = sb.pop_front();
        check("ch_width", ch_width, mon_e.w);
        check("frame_count", WW'(frame_count), WW'(mon_e.fc));
        check("err_at_commit", WW'(err_count), WW'(mon_e.ec));
        check("lost_at_commit", WW'(signal_lost), '0);
        exp_w = mon_e.w;
      end
    end else begin
      check("ch_width_hold", ch_width, exp_w);
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  task automatic next_rise(int p);
    cyc(p - PW);
    ppm_in = 1'b1;
    model_rise(p);
    cyc(PW);
    ppm_in = 1'b0;
    check("state_dbg", WW'(state_dbg), WW'(exp_state()));
    check("err_count", WW'(err_count), WW'(m_err));
  endtask

  task automatic send_frame(int gap, int nch, bit rnd, int special);
    int v;
    next_rise(gap);
    next_rise(rnd ? int'($urandom_range(200, 50)) : 80);
    for (int k = 0; k < nch; k++) begin
      v = rnd ? int'($urandom_range(200, 50)) : 100 + 10 * k;
      if (k == special) v = SYNC_MIN - 1;
      next_rise(v);
    end
  endtask

  task automatic check_zero(string nm);
    check({nm, "_width"}, ch_width, '0);
    check({nm, "_fv"}, WW'(frame_valid), '0);
    check({nm, "_fc"}, WW'(frame_count), '0);
    check({nm, "_ec"}, WW'(err_count), '0);
    check({nm, "_lost"}, WW'(signal_lost), '0);
    check({nm, "_state"}, WW'(state_dbg), '0);
  endtask

  initial begin
    #1_200_000;
    n_chk++;
    n_fail++;
    $display("FAIL watchdog: got time limit expected end of stimulus");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    int r, nch, sp, gap;
    repeat (3) @(posedge ACLK);
    #1;
    check_zero("reset");
    ARESETN = 1'b1;
    enable  = 1'b1;

    // three good frames: first gap only syncs
    for (int i = 0; i < 3; i++) send_frame(3000, 6, 0, -1);
    check("fc_after_3", WW'(frame_count), WW'(m_fc));

    // short frame, then a good one
    send_frame(1200, 5, 0, -1);
    send_frame(1200, 6, 0, -1);

    // overlong frame, then a good one
    send_frame(1200, 7, 0, -1);
    send_frame(1200, 6, 0, -1);

    // input stuck low long enough to lose the signal
    next_rise(1200);
    cyc(9900 - PW);
    check("lost_early", WW'(signal_lost), '0);
    cyc(200);
    check("lost_set", WW'(signal_lost), WW'(1));
    check("lost_state", WW'(state_dbg), '0);
    cyc(12000 - 10100);
    ppm_in = 1'b1;
    model_rise(12000);
    cyc(PW);
    ppm_in = 1'b0;
    next_rise(80);
    for (int k = 0; k < NUM_CH; k++) next_rise(60 + 7 * k);

    // gap of TIMEOUT+1: rise coincides with saturation
    send_frame(TIMEOUT + 1, 6, 0, 3);
    check("lost_cleared", WW'(signal_lost), '0);
    check("lost_rise_wins", WW'(signal_lost), WW'(m_lost));
    send_frame(SYNC_MIN, 6, 0, 2);

    // enable dropped mid-frame
    next_rise(1200);
    next_rise(80);
    for (int k = 0; k < 3; k++) next_rise(150);
    cyc(30);
    enable = 1'b0;
    model_idle();
    cyc(500);
    check("dis_state", WW'(state_dbg), '0);
    check("dis_lost", WW'(signal_lost), '0);
    enable = 1'b1;
    for (int k = 0; k < 3; k++) next_rise(150);
    send_frame(1200, 6, 0, -1);

    // randomized frames, occasionally malformed
    for (int i = 0; i < 6; i++) begin
      r   = int'($urandom_range(4, 0));
      nch = (r == 0) ? 5 : ((r == 4) ? 7 : 6);
      sp  = ($urandom_range(7, 0) == 0) ?
            int'($urandom_range(nch - 1, 0)) : -1;
      gap = ($urandom_range(3, 0) == 0) ?
            SYNC_MIN : int'($urandom_range(1500, SYNC_MIN));
      send_frame(gap, nch, 1, sp);
    end

    // asynchronous reset in the middle of a capture
    next_rise(1200);
    next_rise(80);
    next_rise(120);
    cyc(40);
    check("sb_before_reset", WW'(sb.size()), '0);
    #2 ARESETN = 1'b0;
    #1;
    check_zero("async_reset");
    ppm_in = 1'b0;
    model_idle();
    m_fc   = 0;
    m_err  = 0;
    m_lost = 0;
    cyc(5);
    ARESETN = 1'b1;
    send_frame(3000, 6, 1, -1);
    send_frame(1200, 6, 1, -1);
    next_rise(1200);

    cyc(10);
    check("final_fc", WW'(frame_count), WW'(m_fc));
    check("final_ec", WW'(err_count), WW'(m_err));
    check("final_lost", WW'(signal_lost), WW'(m_lost));
    check("sb_drained", WW'(sb.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
